// File: rtl/jtag_counter_top.sv
// JTAG TAP wrapper around a 4-bit up/down counter core.
// The JTAG pins are oversampled in the sys_clk domain and have no clock of their own.
module jtag_counter_top (
  input  logic       sys_clk,
  input  logic       sys_reset_n,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  input  logic       trst_n,
  inout  wire        up_down_ext,
  output logic [3:0] count_ext,
  output logic [3:0] count_oe_ext
);

  localparam logic [31:0] IDCODE_VAL = 32'h1A5B_C0DF;
  localparam logic [3:0]  IR_EXTEST  = 4'b0000;
  localparam logic [3:0]  IR_IDCODE  = 4'b0001;
  localparam logic [3:0]  IR_SAMPLE  = 4'b0010;

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_t;

  tap_state_t  state, state_next;
  logic [2:0]  tck_sync;
  logic [1:0]  tms_sync, tdi_sync, trst_sync;
  logic        tck_rise, tck_fall, tms_s, tdi_s, trst_s;
  logic [3:0]  ir, ir_shift;
  logic [31:0] idcode_sr;
  logic        bypass_sr;
  logic [10:0] bsr, bsr_update, bsr_capture;
  logic [3:0]  count;
  logic        sel_idcode, sel_bsr, extest, dr_tdo;

  // tck_sync[2] is the previous synchronized value, used for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      tck_sync  <= 3'b000;
      tms_sync  <= 2'b00;
      tdi_sync  <= 2'b00;
      trst_sync <= 2'b00;
    end else begin
      tck_sync  <= {tck_sync[1:0], tck};
      tms_sync  <= {tms_sync[0], tms};
      tdi_sync  <= {tdi_sync[0], tdi};
      trst_sync <= {trst_sync[0], trst_n};
    end
  end

  assign tck_rise = tck_sync[1] & ~tck_sync[2];
  assign tck_fall = ~tck_sync[1] & tck_sync[2];
  assign tms_s    = tms_sync[1];
  assign tdi_s    = tdi_sync[1];
  assign trst_s   = trst_sync[1];

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n || !trst_s) state <= TLR;
    else if (tck_rise)           state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TLR:    state_next = tms_s ? TLR    : RTI;
      RTI:    state_next = tms_s ? SEL_DR : RTI;
      SEL_DR: state_next = tms_s ? SEL_IR : CAP_DR;
      CAP_DR: state_next = tms_s ? EX1_DR : SH_DR;
      SH_DR:  state_next = tms_s ? EX1_DR : SH_DR;
      EX1_DR: state_next = tms_s ? UPD_DR : PAU_DR;
      PAU_DR: state_next = tms_s ? EX2_DR : PAU_DR;
      EX2_DR: state_next = tms_s ? UPD_DR : SH_DR;
      UPD_DR: state_next = tms_s ? SEL_DR : RTI;
      SEL_IR: state_next = tms_s ? TLR    : CAP_IR;
      CAP_IR: state_next = tms_s ? EX1_IR : SH_IR;
      SH_IR:  state_next = tms_s ? EX1_IR : SH_IR;
      EX1_IR: state_next = tms_s ? UPD_IR : PAU_IR;
      PAU_IR: state_next = tms_s ? EX2_IR : PAU_IR;
      EX2_IR: state_next = tms_s ? UPD_IR : SH_IR;
      UPD_IR: state_next = tms_s ? SEL_DR : RTI;
      default: state_next = TLR;
    endcase
  end

  // Unassigned instruction codes fall through to BYPASS.
  assign sel_idcode  = (ir == IR_IDCODE);
  assign sel_bsr     = (ir == IR_EXTEST) || (ir == IR_SAMPLE);
  assign extest      = (ir == IR_EXTEST);
  assign dr_tdo      = sel_idcode ? idcode_sr[0] : (sel_bsr ? bsr[0] : bypass_sr);
  assign bsr_capture = {4'hF, count, 1'b0, 1'b0, up_down_ext};

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n) begin
      ir         <= IR_IDCODE;
      ir_shift   <= 4'b0000;
      idcode_sr  <= 32'd0;
      bypass_sr  <= 1'b0;
      bsr        <= 11'd0;
      bsr_update <= 11'd0;
      tdo        <= 1'b0;
    end else begin
      if (tck_rise) begin
        case (state)
          CAP_IR: ir_shift <= 4'b0101;
          SH_IR:  ir_shift <= {tdi_s, ir_shift[3:1]};
          CAP_DR: begin
            if (sel_idcode)   idcode_sr <= IDCODE_VAL;
            else if (sel_bsr) bsr       <= bsr_capture;
            else              bypass_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_idcode)   idcode_sr <= {tdi_s, idcode_sr[31:1]};
            else if (sel_bsr) bsr       <= {tdi_s, bsr[10:1]};
            else              bypass_sr <= tdi_s;
          end
          default: ;
        endcase
      end
      if (tck_fall) begin
        if (state == UPD_IR)            ir         <= ir_shift;
        if (state == UPD_DR && sel_bsr) bsr_update <= bsr;
        if (state == SH_IR)             tdo        <= ir_shift[0];
        else if (state == SH_DR)        tdo        <= dr_tdo;
        else                            tdo        <= 1'b0;
      end
      if (state == TLR) ir <= IR_IDCODE;
      // TRST clears only the TAP side; the update latch and core keep running.
      if (!trst_s) begin
        ir       <= IR_IDCODE;
        ir_shift <= 4'b0000;
        tdo      <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_reset_n)  count <= 4'd0;
    else if (!extest)  count <= up_down_ext ? count + 4'd1 : count - 4'd1;
  end

  assign count_ext    = extest ? bsr_update[6:3]  : count;
  assign count_oe_ext = extest ? bsr_update[10:7] : 4'hF;
  assign up_down_ext  = (extest && bsr_update[2]) ? bsr_update[1] : 1'bz;

endmodule

// File: tb/tb_jtag_counter_top.sv
// Randomized bench for jtag_counter_top: JTAG host tasks plus a spec-level model
// of IDCODE, BYPASS delay, IR capture, BSR capture/update and counter arithmetic.
module tb_jtag_counter_top;

  logic       sys_clk = 1'b0;
  logic       sys_reset_n, tck, tms, tdi, trst_n;
  logic       tdo;
  logic [3:0] count_ext, count_oe_ext;
  logic       ud_en, ud_val;
  wire        up_down_ext;

  int checks   = 0;
  int failures = 0;

  pullup (up_down_ext);
  assign up_down_ext = ud_en ? ud_val : 1'bz;

  jtag_counter_top dut (
    .sys_clk      (sys_clk),
    .sys_reset_n  (sys_reset_n),
    .tck          (tck),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .trst_n       (trst_n),
    .up_down_ext  (up_down_ext),
    .count_ext    (count_ext),
    .count_oe_ext (count_oe_ext)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic jtag_clock(input logic tms_v, input logic tdi_v);
    tms = tms_v;
    tdi = tdi_v;
    repeat (4) @(negedge sys_clk);
    tck = 1'b1;
    repeat (5) @(negedge sys_clk);
    tck = 1'b0;
    repeat (5) @(negedge sys_clk);
  endtask

  // Called in a Shift state: tdo already holds bit 0; the last shift exits to Exit1.
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      jtag_clock(i == n - 1, din[i]);
    end
  endtask

  task automatic ir_scan(input logic [3:0] code, output logic [63:0] dout);
    jtag_clock(1, 0); jtag_clock(1, 0); jtag_clock(0, 0); jtag_clock(0, 0);
    shift_bits(4, {60'd0, code}, dout);
    jtag_clock(1, 0); jtag_clock(0, 0);
    $display("ir_scan code=%h out=%h", code, dout[3:0]);
  endtask

  task automatic dr_scan(input int n, input logic [63:0] din, output logic [63:0] dout);
    jtag_clock(1, 0); jtag_clock(0, 0); jtag_clock(0, 0);
    shift_bits(n, din, dout);
    jtag_clock(1, 0); jtag_clock(0, 0);
    $display("dr_scan n=%0d in=%h out=%h", n, din, dout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] out, out1, out2;
    logic [3:0]  exp_cnt, c0, rc, ro, code;
    logic [15:0] din16;
    logic [10:0] pre;
    logic        dir;

    sys_reset_n = 1'b0; trst_n = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
    ud_en = 1'b0; ud_val = 1'b1;
    repeat (5) @(negedge sys_clk);
    check_value("reset_count", count_ext, 4'h0);
    check_value("reset_oe", count_oe_ext, 4'hF);
    check_value("reset_tdo", tdo, 1'b0);
    check_value("reset_updown_z", up_down_ext, 1'b1);

    // Counter: up through full wrap, then reverse at zero, then random directions.
    ud_en = 1'b1; ud_val = 1'b1; sys_reset_n = 1'b1; exp_cnt = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      exp_cnt = exp_cnt + 4'd1;
      check_value("count_up", count_ext, exp_cnt);
    end
    ud_val = 1'b0; exp_cnt = exp_cnt - 4'd1;
    @(negedge sys_clk);
    check_value("count_wrap_down", count_ext, exp_cnt);
    for (int i = 0; i < 24; i++) begin
      dir = 1'($urandom_range(0, 1));
      ud_val = dir;
      exp_cnt = dir ? exp_cnt + 4'd1 : exp_cnt - 4'd1;
      @(negedge sys_clk);
      check_value("count_rand", count_ext, exp_cnt);
    end
    ud_en = 1'b0;
    $display("counter sequence done final=%h", count_ext);

    // IDCODE after Test-Logic-Reset.
    repeat (5) jtag_clock(1, 0);
    jtag_clock(0, 0);
    check_value("tdo_idle", tdo, 1'b0);
    dr_scan(32, 64'd0, out);
    check_value("idcode", out[31:0], 32'h1A5B_C0DF);

    // BYPASS: one-bit delay with leading captured 0.
    ir_scan(4'hF, out);
    check_value("ir_capture", out[3:0], 4'b0101);
    dr_scan(5, 64'b01101, out);
    check_value("bypass_fixed", out[4:0], 5'b11010);
    for (int k = 0; k < 4; k++) begin
      code = 4'($urandom_range(3, 14));
      ir_scan(code, out);
      check_value("ir_capture_rand", out[3:0], 4'b0101);
      din16 = 16'($urandom);
      dr_scan(16, {48'd0, din16}, out);
      check_value("bypass_rand", out[15:0], {din16[14:0], 1'b0});
    end

    // SAMPLE/PRELOAD: count=A, oe=5, up_down oe=1 data=0.
    ir_scan(4'h2, out);
    pre = {4'h5, 4'hA, 1'b1, 1'b0, 1'b0};
    dr_scan(11, {53'd0, pre}, out);
    check_value("sample_pin", out[0], 1'b1);
    check_value("sample_ud_cells", out[2:1], 2'b00);
    check_value("sample_oe_cells", out[10:7], 4'hF);
    check_value("sample_func_oe", count_oe_ext, 4'hF);

    ir_scan(4'h0, out);
    check_value("extest_count", count_ext, 4'hA);
    check_value("extest_oe", count_oe_ext, 4'h5);
    check_value("extest_updown", up_down_ext, 1'b0);

    // Two EXTEST captures: the core count must not move between them.
    dr_scan(11, {53'd0, pre}, out1);
    check_value("extest_cap_pin", out1[0], 1'b0);
    check_value("extest_cap_oe", out1[10:7], 4'hF);
    rc = 4'($urandom_range(0, 15));
    ro = 4'($urandom_range(0, 15));
    dr_scan(11, {53'd0, ro, rc, 1'b0, 1'b1, 1'b0}, out2);
    check_value("extest_frozen", out2[6:3], out1[6:3]);
    check_value("extest_rand_count", count_ext, rc);
    check_value("extest_rand_oe", count_oe_ext, ro);
    check_value("extest_rand_updown_z", up_down_ext, 1'b1);

    // TRST pulse in EXTEST returns to IDCODE and functional pins.
    trst_n = 1'b0;
    repeat (5) @(negedge sys_clk);
    trst_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check_value("trst_oe", count_oe_ext, 4'hF);
    check_value("trst_updown_z", up_down_ext, 1'b1);
    check_value("trst_tdo", tdo, 1'b0);
    c0 = count_ext;
    @(negedge sys_clk);
    check_value("trst_count_runs", count_ext, c0 + 4'd1);
    jtag_clock(0, 0);
    dr_scan(32, 64'd0, out);
    check_value("trst_idcode", out[31:0], 32'h1A5B_C0DF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
